// File: rtl/wide_add_seq_pkg.sv
// Shared types for the word-serial wide adder: controller state encoding.
// Optional subtract mode is enabled by defining WIDE_ADD_SEQ_SUB_EN.
package wide_add_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/result bus of the wide adder. Both sides are valid/ready: a transfer
// happens on a rising edge where valid && ready; the source holds its payload until then.
interface wide_add_seq_if #(parameter int W = 16);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

`ifdef WIDE_ADD_SEQ_SUB_EN
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
`endif

endinterface

// File: rtl/wide_add_seq_adder_slice.sv
// Combinational N-bit ripple-carry adder slice with carry in and carry out.
module adder_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic c;

    // Carry kept as a block-local variable so the chain is not a self-feeding vector.
    always_comb begin
        c = cin_i;
        sum_o = '0;
        for (int i = 0; i < N; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial wide adder: one shared N-bit slice walks WORDS chunks, low chunk first.
// Defining WIDE_ADD_SEQ_SUB_EN adds in_sub for a - b (carry-out = no borrow).
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic           clk,
    input  logic           reset,
    wide_add_seq_if.slave  bus,
    output state_t         dbg_state_o
);

    localparam int W    = N * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;

    logic [N-1:0]    slice_a, slice_b, slice_sum;
    logic            slice_cout;

`ifdef WIDE_ADD_SEQ_SUB_EN
    logic            sub_q, sub_d;
`endif

    always_comb begin
        slice_a = N'(a_q >> (int'(idx_q) * N));
        slice_b = N'(b_q >> (int'(idx_q) * N));
`ifdef WIDE_ADD_SEQ_SUB_EN
        if (sub_q) slice_b = ~slice_b;
`endif
    end

    adder_slice #(.N(N)) u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef WIDE_ADD_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    idx_d   = '0;
                    carry_d = bus.in_cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
                    sub_d   = bus.in_sub;
                    if (bus.in_sub) carry_d = 1'b1;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                // Partial result stays in res_q so out_sum only moves when a full sum is ready.
                res_d[int'(idx_q) * N +: N] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    sum_d   = res_d;
                    cout_d  = slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef WIDE_ADD_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq (N=4, WORDS=4); covers WIDE_ADD_SEQ_SUB_EN when defined.
module tb_wide_add_seq;
    import wide_add_seq_pkg::*;

    logic   clk;
    logic   reset;
    state_t dbg_state;
    int     checks;
    int     passed;

    wide_add_seq_if #(.W(16)) bus ();

    wide_add_seq #(.N(4), .WORDS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at a falling edge; returns one falling edge after the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = 16'hDEAD;
        bus.in_b     = 16'hBEEF;
        bus.in_cin   = ~cin;
    endtask

    // Counts rising edges until out_valid is seen, bounded at 20.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) $display("FAIL reset_flags got %b want 100", {bus.in_ready, bus.out_valid, bus.busy});
        else passed++;
        checks++;
        if ({bus.out_cout, bus.out_sum} !== 17'h0) $display("FAIL reset_sum got %h want 00000", {bus.out_cout, bus.out_sum});
        else passed++;
        checks++;
        if (dbg_state !== IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE);
        else passed++;
    endtask

    task automatic test_basic_add();
        int lat;
        bus.out_ready = 1'b1;
        send(16'h1234, 16'h4321, 1'b0);
        checks++;
        if ({bus.in_ready, bus.busy} !== 2'b01) $display("FAIL basic_run_flags got %b want 01", {bus.in_ready, bus.busy});
        else passed++;
        wait_valid(lat);
        checks++;
        if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat);
        else passed++;
        checks++;
        if ({bus.out_cout, bus.out_sum} !== {1'b0, 16'h5555}) $display("FAIL basic_sum got %h want 05555", {bus.out_cout, bus.out_sum});
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) $display("FAIL basic_one_cycle got %b want 010", {bus.out_valid, bus.in_ready, bus.busy});
        else passed++;
    endtask

    task automatic test_carry_chain();
        int lat;
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 4 || {bus.out_cout, bus.out_sum} !== {1'b1, 16'h0000}) $display("FAIL carry_full got lat %0d sum %h want lat 4 sum 10000", lat, {bus.out_cout, bus.out_sum});
        else passed++;
        @(negedge clk);
        send(16'h00FF, 16'h0000, 1'b1);
        wait_valid(lat);
        checks++;
        if (lat !== 4 || {bus.out_cout, bus.out_sum} !== {1'b0, 16'h0100}) $display("FAIL carry_cin got lat %0d sum %h want lat 4 sum 00100", lat, {bus.out_cout, bus.out_sum});
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        bus.out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 4 || {bus.out_cout, bus.out_sum} !== {1'b0, 16'h3333}) $display("FAIL bp_first got lat %0d sum %h want lat 4 sum 03333", lat, {bus.out_cout, bus.out_sum});
        else passed++;
        bus.in_a     = 16'h0101;
        bus.in_b     = 16'h0202;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== 16'h3333 || bus.out_cout !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        else passed++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL bp_release got %b want 01", {bus.out_valid, bus.in_ready});
        else passed++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL bp_pending_accept got busy %b want 1", bus.busy);
        else passed++;
        wait_valid(lat);
        checks++;
        if (lat !== 4 || {bus.out_cout, bus.out_sum} !== {1'b0, 16'h0303}) $display("FAIL bp_second got lat %0d sum %h want lat 4 sum 00303", lat, {bus.out_cout, bus.out_sum});
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int seen;
        send(16'h8888, 16'h8888, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) $display("FAIL abort_flags got %b want 001", {bus.out_valid, bus.busy, bus.in_ready});
        else passed++;
        checks++;
        if ({bus.out_cout, bus.out_sum} !== 17'h0) $display("FAIL abort_sum got %h want 00000", {bus.out_cout, bus.out_sum});
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL abort_no_result got %0d bad cycles want 0", seen);
        else passed++;
    endtask

`ifdef WIDE_ADD_SEQ_SUB_EN
    task automatic test_subtract();
        int lat;
        bus.in_sub = 1'b1;
        send(16'h0005, 16'h0007, 1'b0);
        bus.in_sub = 1'b0;
        wait_valid(lat);
        checks++;
        if (lat !== 4 || {bus.out_cout, bus.out_sum} !== {1'b0, 16'hFFFE}) $display("FAIL sub_neg got lat %0d sum %h want lat 4 sum 0fffe", lat, {bus.out_cout, bus.out_sum});
        else passed++;
        @(negedge clk);
        bus.in_sub = 1'b1;
        send(16'h0007, 16'h0005, 1'b1);
        bus.in_sub = 1'b0;
        wait_valid(lat);
        checks++;
        if (lat !== 4 || {bus.out_cout, bus.out_sum} !== {1'b1, 16'h0002}) $display("FAIL sub_pos got lat %0d sum %h want lat 4 sum 10002", lat, {bus.out_cout, bus.out_sum});
        else passed++;
        @(negedge clk);
    endtask
`endif

    initial begin
        checks        = 0;
        passed        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
        bus.in_sub    = 1'b0;
`endif
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_run();
`ifdef WIDE_ADD_SEQ_SUB_EN
        test_subtract();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
